// File: rtl/core_req_bank_dispatch_pkg.sv
// Shared address-split helpers and per-port request record
// for the request-side bank dispatcher.
package core_req_bank_dispatch_pkg;

   localparam int CFG_NUM_REQS       = 4;
   localparam int CFG_NUM_BANKS      = 4;
   localparam int CFG_WORD_SIZE      = 4;
   localparam int CFG_WORDS_PER_LINE = 4;
   localparam int CFG_WORD_ADDR_W    = 30;

   localparam int WSEL_BITS = $clog2(CFG_WORDS_PER_LINE);
   localparam int BANK_BITS =
      (CFG_NUM_BANKS > 1) ? $clog2(CFG_NUM_BANKS) : 1;
   localparam int REQS_BITS =
      (CFG_NUM_REQS > 1) ? $clog2(CFG_NUM_REQS) : 1;
   localparam int LINE_BITS = CFG_WORD_ADDR_W - WSEL_BITS;

   typedef logic [LINE_BITS-1:0] line_t;

   typedef struct packed {
      logic                         rw;
      logic [CFG_WORD_ADDR_W-1:0]   addr;
      logic [CFG_WORD_SIZE-1:0]     byteen;
      logic [8*CFG_WORD_SIZE-1:0]   data;
      logic [REQS_BITS-1:0]         tid;
   } port_req_t;

   function automatic logic [BANK_BITS-1:0] get_bank(
      input logic [CFG_WORD_ADDR_W-1:0] addr
   );
      if (CFG_NUM_BANKS == 1) return '0;
      return addr[WSEL_BITS +: BANK_BITS];
   endfunction

   function automatic line_t get_line(
      input logic [CFG_WORD_ADDR_W-1:0] addr
   );
      return addr[CFG_WORD_ADDR_W-1:WSEL_BITS];
   endfunction

endpackage

// File: rtl/core_req_bank_out_reg.sv
// Per-bank 1-entry valid/ready stage; plain wires when
// OUT_REG = 0, full-throughput skid-free register otherwise.
module core_req_bank_out_reg #(
   parameter int WIDTH   = 1,
   parameter bit OUT_REG = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   if (OUT_REG) begin : g_reg
      logic             full_r;
      logic [WIDTH-1:0] data_r;

      // accepts while empty or while the held entry drains
      assign in_ready  = !full_r || out_ready;
      assign out_valid = full_r;
      assign out_data  = data_r;

      always_ff @(posedge clk) begin
         if (reset)
            full_r <= 1'b0;
         else if (in_ready)
            full_r <= in_valid;
      end

      always_ff @(posedge clk) begin
         if (in_valid && in_ready)
            data_r <= in_data;
      end
   end else begin : g_pass
      logic unused;
      assign unused    = ^{clk, reset};
      assign in_ready  = out_ready;
      assign out_valid = in_valid;
      assign out_data  = in_data;
   end

endmodule

// File: rtl/core_req_bank_dispatch.sv
// Steers a core request batch to banks, coalescing same-line lanes.
// CORE_REQ_DISPATCH_PERF_EN adds the perf_bank_stalls counter.
module core_req_bank_dispatch
   import core_req_bank_dispatch_pkg::*;
#(
   parameter int NUM_REQS        = 4,
   parameter int NUM_BANKS       = 4,
   parameter int NUM_PORTS       = 2,
   parameter int WORD_SIZE       = 4,
   parameter int WORDS_PER_LINE  = 4,
   parameter int WORD_ADDR_WIDTH = 30,
   parameter int CORE_TAG_WIDTH  = 8,
   parameter bit OUT_REG         = 1'b0
) (
   input  logic clk,
   input  logic reset,
`ifdef CORE_REQ_DISPATCH_PERF_EN
   output logic [31:0] perf_bank_stalls,
`endif
   input  logic                       core_req_valid,
   input  logic [NUM_REQS-1:0]        core_req_tmask,
   input  logic [NUM_REQS-1:0]        core_req_rw,
   input  logic [NUM_REQS-1:0][WORD_ADDR_WIDTH-1:0] core_req_addr,
   input  logic [NUM_REQS-1:0][WORD_SIZE-1:0]       core_req_byteen,
   input  logic [NUM_REQS-1:0][8*WORD_SIZE-1:0]     core_req_data,
   input  logic [CORE_TAG_WIDTH-1:0]  core_req_tag,
   output logic                       core_req_ready,
   output logic [NUM_BANKS-1:0]       per_bank_req_valid,
   output logic [NUM_BANKS-1:0][NUM_PORTS-1:0] per_bank_req_pmask,
   output logic [NUM_BANKS-1:0][NUM_PORTS-1:0] per_bank_req_rw,
   output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WORD_ADDR_WIDTH-1:0]
                                      per_bank_req_addr,
   output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WORD_SIZE-1:0]
                                      per_bank_req_byteen,
   output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][8*WORD_SIZE-1:0]
                                      per_bank_req_data,
   output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][REQS_BITS-1:0]
                                      per_bank_req_tid,
   output logic [NUM_BANKS-1:0][CORE_TAG_WIDTH-1:0] per_bank_req_tag,
   input  logic [NUM_BANKS-1:0]       per_bank_req_ready
);

   localparam int PW =
      CORE_TAG_WIDTH + NUM_PORTS + NUM_PORTS * $bits(port_req_t);

   // the record layout is fixed by the shared package
   if (NUM_REQS != CFG_NUM_REQS || NUM_BANKS != CFG_NUM_BANKS ||
       WORD_SIZE != CFG_WORD_SIZE ||
       WORDS_PER_LINE != CFG_WORDS_PER_LINE ||
       WORD_ADDR_WIDTH != CFG_WORD_ADDR_W ||
       NUM_PORTS > NUM_REQS) begin : g_cfg_err
      $error("core_req_bank_dispatch: parameters disagree with package");
   end

   logic [NUM_REQS-1:0] sent_r;
   logic [NUM_REQS-1:0] sent_n;
   logic [NUM_REQS-1:0] pending;
   logic [NUM_REQS-1:0] dispatched;
   logic [NUM_BANKS-1:0][NUM_REQS-1:0] bank_disp;

   assign pending = {NUM_REQS{core_req_valid}}
                  & core_req_tmask & ~sent_r;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [NUM_REQS-1:0]  sel;
      logic                 found;
      line_t                lead;
      int                   cnt;
      logic [NUM_PORTS-1:0] pmask;
      port_req_t [NUM_PORTS-1:0] ports;
      port_req_t [NUM_PORTS-1:0] out_ports;
      logic                 in_ready;
      logic [PW-1:0]        out_data;

      // leader is the lowest pending lane; same-line followers
      // take the next free ports in lane order
      always_comb begin
         sel   = '0;
         found = 1'b0;
         lead  = '0;
         cnt   = 0;
         pmask = '0;
         ports = '0;
         for (int i = 0; i < NUM_REQS; i++) begin
            if (pending[i] &&
                get_bank(core_req_addr[i]) == BANK_BITS'(b)) begin
               if (!found ||
                   (get_line(core_req_addr[i]) == lead &&
                    cnt < NUM_PORTS)) begin
                  for (int p = 0; p < NUM_PORTS; p++) begin
                     if (p == cnt) begin
                        pmask[p]        = 1'b1;
                        ports[p].rw     = core_req_rw[i];
                        ports[p].addr   = core_req_addr[i];
                        ports[p].byteen = core_req_byteen[i];
                        ports[p].data   = core_req_data[i];
                        ports[p].tid    = REQS_BITS'(i);
                     end
                  end
                  if (!found)
                     lead = get_line(core_req_addr[i]);
                  found  = 1'b1;
                  sel[i] = 1'b1;
                  cnt    = cnt + 1;
               end
            end
         end
      end

      assign bank_disp[b] = (found && in_ready) ? sel : '0;

      core_req_bank_out_reg #(
         .WIDTH   (PW),
         .OUT_REG (OUT_REG)
      ) u_out_reg (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (found),
         .in_data   ({core_req_tag, pmask, ports}),
         .in_ready  (in_ready),
         .out_valid (per_bank_req_valid[b]),
         .out_data  (out_data),
         .out_ready (per_bank_req_ready[b])
      );

      assign {per_bank_req_tag[b], per_bank_req_pmask[b],
              out_ports} = out_data;

      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
         assign per_bank_req_rw[b][p]     = out_ports[p].rw;
         assign per_bank_req_addr[b][p]   = out_ports[p].addr;
         assign per_bank_req_byteen[b][p] = out_ports[p].byteen;
         assign per_bank_req_data[b][p]   = out_ports[p].data;
         assign per_bank_req_tid[b][p]    = out_ports[p].tid;
      end
   end

   always_comb begin
      dispatched = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         dispatched = dispatched | bank_disp[b];
   end

   assign sent_n         = sent_r | dispatched;
   assign core_req_ready = core_req_valid && (sent_n == core_req_tmask);

   always_ff @(posedge clk) begin
      if (reset)
         sent_r <= '0;
      else if (core_req_valid)
         sent_r <= core_req_ready ? '0 : sent_n;
   end

`ifdef CORE_REQ_DISPATCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset)
         perf_bank_stalls <= '0;
      else if (core_req_valid && !core_req_ready)
         perf_bank_stalls <= perf_bank_stalls + 32'd1;
   end
`endif

endmodule

// File: tb/tb_core_req_bank_dispatch.sv
// Directed-vector bench for core_req_bank_dispatch, covering the
// combinational build and a registered-output instance.
module tb_core_req_bank_dispatch;

   localparam int NR = 4;
   localparam int NB = 4;
   localparam int NP = 2;
   localparam int AW = 30;
   localparam int TW = 8;
   localparam int RB = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                    valid;
   logic [NR-1:0]           tmask;
   logic [NR-1:0]           rw;
   logic [NR-1:0][AW-1:0]   addr;
   logic [NR-1:0][3:0]      byteen;
   logic [NR-1:0][31:0]     data;
   logic [TW-1:0]           tag;
   logic [NB-1:0]           bank_ready;

   logic                        c_ready;
   logic [NB-1:0]               b_valid;
   logic [NB-1:0][NP-1:0]       b_pmask;
   logic [NB-1:0][NP-1:0]       b_rw;
   logic [NB-1:0][NP-1:0][AW-1:0] b_addr;
   logic [NB-1:0][NP-1:0][3:0]  b_byteen;
   logic [NB-1:0][NP-1:0][31:0] b_data;
   logic [NB-1:0][NP-1:0][RB-1:0] b_tid;
   logic [NB-1:0][TW-1:0]       b_tag;

   logic                        r_ready;
   logic [NB-1:0]               r_valid;
   logic [NB-1:0][NP-1:0]       r_pmask;
   logic [NB-1:0][NP-1:0]       r_rw;
   logic [NB-1:0][NP-1:0][AW-1:0] r_addr;
   logic [NB-1:0][NP-1:0][3:0]  r_byteen;
   logic [NB-1:0][NP-1:0][31:0] r_data;
   logic [NB-1:0][NP-1:0][RB-1:0] r_tid;
   logic [NB-1:0][TW-1:0]       r_tag;

`ifdef CORE_REQ_DISPATCH_PERF_EN
   logic [31:0] b_perf;
   logic [31:0] r_perf;
   logic [31:0] perf_snap;
`endif

   core_req_bank_dispatch #(.OUT_REG(1'b0)) dut (
      .clk                 (clk),
      .reset               (reset),
`ifdef CORE_REQ_DISPATCH_PERF_EN
      .perf_bank_stalls    (b_perf),
`endif
      .core_req_valid      (valid),
      .core_req_tmask      (tmask),
      .core_req_rw         (rw),
      .core_req_addr       (addr),
      .core_req_byteen     (byteen),
      .core_req_data       (data),
      .core_req_tag        (tag),
      .core_req_ready      (c_ready),
      .per_bank_req_valid  (b_valid),
      .per_bank_req_pmask  (b_pmask),
      .per_bank_req_rw     (b_rw),
      .per_bank_req_addr   (b_addr),
      .per_bank_req_byteen (b_byteen),
      .per_bank_req_data   (b_data),
      .per_bank_req_tid    (b_tid),
      .per_bank_req_tag    (b_tag),
      .per_bank_req_ready  (bank_ready)
   );

   core_req_bank_dispatch #(.OUT_REG(1'b1)) dut_r (
      .clk                 (clk),
      .reset               (reset),
`ifdef CORE_REQ_DISPATCH_PERF_EN
      .perf_bank_stalls    (r_perf),
`endif
      .core_req_valid      (valid),
      .core_req_tmask      (tmask),
      .core_req_rw         (rw),
      .core_req_addr       (addr),
      .core_req_byteen     (byteen),
      .core_req_data       (data),
      .core_req_tag        (tag),
      .core_req_ready      (r_ready),
      .per_bank_req_valid  (r_valid),
      .per_bank_req_pmask  (r_pmask),
      .per_bank_req_rw     (r_rw),
      .per_bank_req_addr   (r_addr),
      .per_bank_req_byteen (r_byteen),
      .per_bank_req_data   (r_data),
      .per_bank_req_tid    (r_tid),
      .per_bank_req_tag    (r_tag),
      .per_bank_req_ready  (bank_ready)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [NR-1:0] m,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic [TW-1:0] t);
      valid   = 1'b1;
      tmask   = m;
      addr[0] = a0;
      addr[1] = a1;
      addr[2] = a2;
      addr[3] = a3;
      tag     = t;
   endtask

   initial begin
      reset      = 1'b1;
      valid      = 1'b0;
      tmask      = '0;
      rw         = 4'b1010;
      addr       = '0;
      tag        = '0;
      bank_ready = '1;
      for (int i = 0; i < NR; i++) begin
         byteen[i] = 4'hF;
         data[i]   = 32'hD000_0000 + 32'(i);
      end

      @(negedge clk);
      check("rst_ready",  64'(c_ready), 64'(0));
      check("rst_valid",  64'(b_valid), 64'(0));
      check("rst_rvalid", 64'(r_valid), 64'(0));
      step();
      step();
      reset = 1'b0;

      // four lanes, four banks
      drive(4'hF, 30'h0, 30'h4, 30'h8, 30'hC, 8'h5A);
      @(negedge clk);
      check("s1_valid", 64'(b_valid), 64'(4'hF));
      check("s1_pmask", 64'(b_pmask), 64'(8'h55));
      check("s1_ready", 64'(c_ready), 64'(1));
      check("s1_tid2",  64'(b_tid[2][0]), 64'(2));
      check("s1_addr3", 64'(b_addr[3][0]), 64'(30'hC));
      check("s1_tag1",  64'(b_tag[1]), 64'(8'h5A));
      step();

      // two lanes coalesced on one line of bank 0
      drive(4'h3, 30'h10, 30'h11, 30'h0, 30'h0, 8'h5B);
      @(negedge clk);
      check("s2_valid", 64'(b_valid), 64'(4'h1));
      check("s2_pmask", 64'(b_pmask), 64'(8'h03));
      check("s2_tid",   64'(b_tid[0]), 64'(4'b0100));
      check("s2_data1", 64'(b_data[0][1]), 64'(32'hD000_0001));
      check("s2_rw1",   64'(b_rw[0][1]), 64'(1));
      check("s2_ready", 64'(c_ready), 64'(1));
      step();

      // same bank, distinct lines: serialized
      drive(4'hF, 30'h0, 30'h10, 30'h20, 30'h30, 8'h5C);
`ifdef CORE_REQ_DISPATCH_PERF_EN
      perf_snap = b_perf;
`endif
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("s3_valid", 64'(b_valid), 64'(4'h1));
         check("s3_pmask", 64'(b_pmask), 64'(8'h01));
         check("s3_tid",   64'(b_tid[0][0]), 64'(c));
         check("s3_ready", 64'(c_ready), 64'(c == 3));
         step();
      end
`ifdef CORE_REQ_DISPATCH_PERF_EN
      check("s3_perf", 64'(b_perf - perf_snap), 64'(3));
`endif

      // bank 2 stalled for three cycles
      bank_ready = 4'b1011;
      drive(4'hF, 30'h0, 30'h4, 30'h8, 30'hC, 8'h5D);
      for (int c = 0; c < 4; c++) begin
         if (c == 3)
            bank_ready = 4'hF;
         @(negedge clk);
         if (c == 0)
            check("s4_valid0", 64'(b_valid), 64'(4'hF));
         else
            check("s4_valid",  64'(b_valid), 64'(4'h4));
         check("s4_tid2",  64'(b_tid[2][0]), 64'(2));
         check("s4_ready", 64'(c_ready), 64'(c == 3));
         step();
      end

      // empty mask
      drive(4'h0, 30'h0, 30'h4, 30'h8, 30'hC, 8'h5E);
      @(negedge clk);
      check("s5_ready", 64'(c_ready), 64'(1));
      check("s5_valid", 64'(b_valid), 64'(0));
      step();

      // reset in the middle of a serialized batch
      drive(4'hF, 30'h0, 30'h10, 30'h20, 30'h30, 8'h5F);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("s6_pre_tid", 64'(b_tid[0][0]), 64'(c));
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("s6_tid",   64'(b_tid[0][0]), 64'(c));
         check("s6_ready", 64'(c_ready), 64'(c == 3));
         step();
      end

      // registered outputs, back-to-back batches
      valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(4'hF, 30'h0, 30'h4, 30'h8, 30'hC, 8'h11);
      @(negedge clk);
      check("r0_ready", 64'(r_ready), 64'(1));
      check("r0_valid", 64'(r_valid), 64'(0));
      step();
      drive(4'hF, 30'h10, 30'h14, 30'h18, 30'h1C, 8'h22);
      @(negedge clk);
      check("r1_ready", 64'(r_ready), 64'(1));
      check("r1_valid", 64'(r_valid), 64'(4'hF));
      check("r1_tag0",  64'(r_tag[0]), 64'(8'h11));
      check("r1_addr1", 64'(r_addr[1][0]), 64'(30'h4));
      step();
      valid = 1'b0;
      @(negedge clk);
      check("r2_valid", 64'(r_valid), 64'(4'hF));
      check("r2_tag3",  64'(r_tag[3]), 64'(8'h22));
      check("r2_addr1", 64'(r_addr[1][0]), 64'(30'h14));
      check("r2_pmask", 64'(r_pmask), 64'(8'h55));
      step();
      @(negedge clk);
      check("r3_valid", 64'(r_valid), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errs);
      $finish;
   end

endmodule
